// File: rtl/sprite_blitter.sv
// 1-bpp sprite copier: scans one sprite ROM at a screen origin, one pixel per clock, into vga_adapter.
// Optional macro SPRITE_BLITTER_TRANSPARENT_EN: ROM bit 1 pixels are skipped so the sprite overlays the framebuffer.
module sprite_blitter #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SPR_W       = 80,
  parameter int SPR_H       = 120,
  parameter int NUM_SPRITES = 3,
  parameter int SEL_W       = 2,
  parameter int ADDR_W      = 15,
  parameter int ROM_LATENCY = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [SEL_W-1:0]  sprite_sel,
  input  logic [2:0]        fg_colour,
  input  logic [2:0]        bg_colour,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [SEL_W-1:0]  rom_sel,
  input  logic              rom_q,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LAT  = ROM_LATENCY;
  localparam int          RX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int          RY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [RX_W-1:0]   r_rx;
  logic [RY_W-1:0]   r_ry;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [SEL_W-1:0]  r_sel;
  logic [X_W-1:0]    r_x0;
  logic [Y_W-1:0]    r_y0;
  logic [2:0]        r_fg;
  logic [2:0]        r_bg;
  logic [2:0]        r_drain_cnt;
  logic              r_busy;
  logic              r_done;

  logic [X_W-1:0]    r_px [LAT+1];
  logic [Y_W-1:0]    r_py [LAT+1];
  logic              r_pv [LAT+1];

  logic              w_last_col;
  logic              w_last_row;
  logic [X_W:0]      w_sx;
  logic [Y_W:0]      w_sy;
  logic              w_in;
  logic              w_sel_ok;
  logic              w_plot;

  assign w_last_col = (r_rx == RX_W'(SPR_W - 1));
  assign w_last_row = (r_ry == RY_W'(SPR_H - 1));
  // One extra bit so origins near the edge clip instead of wrapping onto the left/top.
  assign w_sx       = (X_W+1)'(r_x0) + (X_W+1)'(r_rx);
  assign w_sy       = (Y_W+1)'(r_y0) + (Y_W+1)'(r_ry);
  assign w_in       = (w_sx < (X_W+1)'(SCREEN_W)) && (w_sy < (Y_W+1)'(SCREEN_H));
  assign w_sel_ok   = (int'(sprite_sel) < NUM_SPRITES);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rx        <= '0;
      r_ry        <= '0;
      r_row_base  <= '0;
      r_rom_addr  <= '0;
      r_sel       <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_fg        <= '0;
      r_bg        <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0       <= x0;
            r_y0       <= y0;
            r_sel      <= w_sel_ok ? sprite_sel : '0;
            r_fg       <= fg_colour;
            r_bg       <= bg_colour;
            r_rx       <= '0;
            r_ry       <= '0;
            r_row_base <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Row base accumulates SPR_W per row instead of multiplying ry*SPR_W.
          r_rom_addr <= r_row_base + ADDR_W'(r_rx);
          if (w_last_col) begin
            r_rx       <= '0;
            r_ry       <= r_ry + RY_W'(1);
            r_row_base <= r_row_base + ADDR_W'(SPR_W);
            if (w_last_row) begin
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
            end
          end else begin
            r_rx <= r_rx + RX_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == 3'(ROM_LATENCY)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage 0 is loaded on the same edge as rom_addr; stage LAT lines up with rom_q.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
        r_pv[i] <= 1'b0;
      end
    end else begin
      r_px[0] <= w_sx[X_W-1:0];
      r_py[0] <= w_sy[Y_W-1:0];
      r_pv[0] <= (r_state == S_SCAN) && w_in;
      for (int unsigned i = 1; i <= LAT; i++) begin
        r_px[i] <= r_px[i-1];
        r_py[i] <= r_py[i-1];
        r_pv[i] <= r_pv[i-1];
      end
    end
  end

`ifdef SPRITE_BLITTER_TRANSPARENT_EN
  assign w_plot = r_pv[LAT] && !rom_q;
`else
  assign w_plot = r_pv[LAT];
`endif

  assign x        = r_px[LAT];
  assign y        = r_py[LAT];
  assign plot     = w_plot;
  assign colour   = w_plot ? (rom_q ? r_bg : r_fg) : 3'b000;
  assign rom_addr = r_rom_addr;
  assign rom_sel  = r_sel;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
